tx_slot_scheduler: RTL
======================

# tx_slot_scheduler

Per-node transmit scheduler and energy ledger for the EER-RL node. It sits between `rewardv2` and the radio interface. It captures a packet request when `rewardv2` signals completion and holds it until the node's TDMA slot comes round. It then grants `okToSend`, waits for the radio acknowledgement with a timeout and retry, and debits the node's energy register using the fixed RX/TX energy costs.

## Interface
Parameters:
- `SLOT_CYCLES`, 64: clock cycles per TDMA slot (≥2).
- `NUM_SLOTS`, 32: slots per frame (≤64).
- `ACK_TIMEOUT`, 255: cycles to wait for `tx_ack` after a grant.
- `MAX_RETRY`, 2: re-grants after a timeout before the request is dropped.
- `LOW_E_THRESH`, 16'h0800: `low_E` asserts when `myEnergy` is below this value.

Ports (direction, width, meaning):
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: slot counter advance enable. Grants also require `en`=1.
- `frame_sync` in 1: restarts the frame.
- `role` in 1: 1 = cluster head, 0 = member.
- `timeslot` in 6: assigned member slot. 6'h3F means unassigned.
- `reward_done` in 1: one-cycle pulse from `rewardv2`; a packet is ready.
- `tx_setting` in 1: sampled with `reward_done`. 0 = 1-hop power, 1 = max (4-hop) power.
- `tx_ack` in 1: one-cycle radio transmit-complete pulse.
- `rx_pkt` in 1: one-cycle pulse; a packet was received.
- `energy_load` in 1: loads `energy_init` into `myEnergy`.
- `energy_init` in 16: initial energy value.
- `okToSend` out 1: one-cycle grant to `rewardv2`/radio.
- `slot_count` out 6: current slot index.
- `myEnergy` out 16: residual energy.
- `low_E` out 1: registered low-energy flag.
- `tx_pending` out 1: a request is held.
- `tx_drop` out 1: one-cycle pulse when a request is abandoned.
- `tx_overrun` out 1: one-cycle pulse when a request is replaced or ignored.

## Operation
- Slot timer:
  - `phase` counts 0..SLOT_CYCLES-1 while `en`=1.
  - When `phase` wraps, `slot_count` increments, wrapping NUM_SLOTS-1→0.
  - `frame_sync` forces phase=0 and slot=0 on the next edge and has priority over `en`.
  - `en`=0 freezes both counters.
- Target slot:
  - `role`=1 targets slot 0.
  - `role`=0 targets `timeslot`.
  - A member with `timeslot`=6'h3F targets NUM_SLOTS-1 (the contention slot).
  - The target is re-evaluated every cycle.
- FSM states: IDLE, WAIT_SLOT, GRANT, WAIT_ACK, DEBIT.
  - IDLE: on `reward_done`, latch `tx_setting`, clear retry count, go to WAIT_SLOT.
  - WAIT_SLOT: when `en`=1, phase==0 and slot_count==target, go to GRANT.
    - `reward_done` in this state relatches `tx_setting`, clears retries, pulses `tx_overrun` and stays.
  - GRANT: `okToSend`=1 for exactly this cycle, then go to WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK:
    - `tx_ack` goes to DEBIT.
    - On timeout (counter reaches ACK_TIMEOUT with no ack): if retries < MAX_RETRY, increment retries and go to WAIT_SLOT (next frame's slot). Otherwise pulse `tx_drop` and go to IDLE with no debit.
    - `tx_ack` in the same cycle the timeout is reached counts as an ack.
  - DEBIT: apply the TX cost, then go to IDLE.
  - `reward_done` in GRANT, WAIT_ACK or DEBIT is ignored and pulses `tx_overrun`.
- `tx_pending` = 1 in WAIT_SLOT, GRANT, WAIT_ACK and DEBIT.
- Energy:
  - TX cost is 16'h0005 (`tx_setting`=0) or 16'h001B (`tx_setting`=1). RX cost is 16'h0004 per `rx_pkt`.
  - RX and TX debits in the same cycle are summed.
  - The result is saturating unsigned 16-bit and floors at 0.
  - `energy_load` overrides any debit that cycle.
  - `tx_ack` outside WAIT_ACK is ignored and debits nothing.
- `low_E` is registered as (myEnergy < LOW_E_THRESH), computed from the updated energy value.

## Timing
- Reset values:
  - FSM = IDLE; phase, `slot_count` and retries = 0.
  - `myEnergy` = 0, `low_E` = 1.
  - `okToSend`, `tx_pending`, `tx_drop`, `tx_overrun` = 0.
- Assertion of `rst` mid-transaction aborts it: no debit, no `tx_drop`.
- `reward_done` at edge t sets `tx_pending` at t+1.
  - Earliest `okToSend` is t+1, if that cycle is phase 0 of the target slot.
  - Otherwise it is the next phase-0 cycle of the target slot.
- `tx_ack` at edge t → DEBIT at t+1 → `myEnergy` updated at t+2 → `low_E` updated at t+3.
- `rx_pkt` at t: `myEnergy` updated at t+1, `low_E` updated at t+2.
- A timeout fires ACK_TIMEOUT+1 cycles after GRANT.
- Grant spacing is one frame minimum: SLOT_CYCLES×NUM_SLOTS cycles.

## Test plan
Bench uses SLOT_CYCLES=4, NUM_SLOTS=8, ACK_TIMEOUT=6, MAX_RETRY=2, and loads `energy_init`=16'h8000 after reset.
- Reset, then `rx_pkt` once → `myEnergy`=16'h7FFC, `low_E`=0, `okToSend` never asserted.
- Member, `timeslot`=3, `reward_done` with `tx_setting`=0 in slot 1 → single `okToSend` at phase 0 of slot 3; `tx_ack` 2 cycles later → `myEnergy` decreases by 5, `tx_pending` clears.
- Member, `timeslot`=6'h3F, `tx_setting`=1 → grant in slot 7; ack together with `rx_pkt` → combined debit 16'h001F.
- CH, no `tx_ack` → grants in slot 0 of three consecutive frames, then `tx_drop` pulse, IDLE, energy unchanged.
- Second `reward_done` while in WAIT_SLOT and again during WAIT_ACK → `tx_overrun` pulses both times; only one grant per frame.
- Load `energy_init`=16'h0003, `tx_setting`=1 transmit → `myEnergy` saturates to 0, `low_E`=1; `frame_sync` mid-frame → `slot_count`=0 next cycle.

Source files
------------

// File: rtl/tx_slot_scheduler.sv
// TDMA transmit scheduler and energy ledger for one EER-RL node.
// Holds one packet request until the node's slot, grants it, tracks the radio ack and debits energy.
module tx_slot_scheduler #(
    parameter int          SLOT_CYCLES  = 64,
    parameter int          NUM_SLOTS    = 32,
    parameter int          ACK_TIMEOUT  = 255,
    parameter int          MAX_RETRY    = 2,
    parameter logic [15:0] LOW_E_THRESH = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        frame_sync,
    input  logic        role,
    input  logic [5:0]  timeslot,
    input  logic        reward_done,
    input  logic        tx_setting,
    input  logic        tx_ack,
    input  logic        rx_pkt,
    input  logic        energy_load,
    input  logic [15:0] energy_init,
    output logic        okToSend,
    output logic [5:0]  slot_count,
    output logic [15:0] myEnergy,
    output logic        low_E,
    output logic        tx_pending,
    output logic        tx_drop,
    output logic        tx_overrun,
    output logic [2:0]  o_dbg_state
);

    localparam int PW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PW-1:0] PH_LAST   = PW'(SLOT_CYCLES - 1);
    localparam logic [5:0]    SLOT_LAST = 6'(NUM_SLOTS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SLOT = 3'd1,
        S_GRANT     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_DEBIT     = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic [5:0]    r_slot;
    logic [5:0]    w_slot_nxt;
    logic [5:0]    w_target;
    logic          w_hit;
    logic          r_tx_set;
    logic [RW-1:0] r_retry;
    logic [TW-1:0] r_to_cnt;
    logic          r_tx_drop;
    logic          r_tx_overrun;
    logic          w_latch;
    logic          w_clr_retry;
    logic          w_inc_retry;
    logic          w_overrun;
    logic          w_drop;
    logic [15:0]   r_energy;
    logic          r_low_e;
    logic [15:0]   w_tx_cost;
    logic [15:0]   w_rx_cost;
    logic [15:0]   w_cost;
    logic [15:0]   w_energy_nxt;

    // Slot timer: frame_sync wins over en; en=0 freezes phase and slot.
    always_comb begin
        w_phase_nxt = r_phase;
        w_slot_nxt  = r_slot;
        if (frame_sync) begin
            w_phase_nxt = '0;
            w_slot_nxt  = '0;
        end else if (en) begin
            if (r_phase == PH_LAST) begin
                w_phase_nxt = '0;
                w_slot_nxt  = (r_slot == SLOT_LAST) ? 6'd0 : r_slot + 6'd1;
            end else begin
                w_phase_nxt = r_phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_slot  <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    assign w_target = role ? 6'd0 : ((timeslot == 6'h3F) ? SLOT_LAST : timeslot);
    // Look one cycle ahead so the GRANT cycle itself is phase 0 of the target slot.
    assign w_hit = en && (w_phase_nxt == '0) && (w_slot_nxt == w_target);

    // Handshake: reward_done is a one-cycle request capture, okToSend a one-cycle
    // grant, and tx_ack a one-cycle completion honoured only while in WAIT_ACK.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_clr_retry = 1'b0;
        w_inc_retry = 1'b0;
        w_overrun   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reward_done) begin
                    w_latch     = 1'b1;
                    w_clr_retry = 1'b1;
                    w_state_nxt = w_hit ? S_GRANT : S_WAIT_SLOT;
                end
            end
            S_WAIT_SLOT: begin
                if (reward_done) begin
                    w_latch     = 1'b1;
                    w_clr_retry = 1'b1;
                    w_overrun   = 1'b1;
                end else if (w_hit) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_overrun   = reward_done;
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                w_overrun = reward_done;
                if (tx_ack) begin
                    w_state_nxt = S_DEBIT;
                end else if (r_to_cnt == TO_LAST) begin
                    if (r_retry < RETRY_MAX) begin
                        w_inc_retry = 1'b1;
                        w_state_nxt = S_WAIT_SLOT;
                    end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DEBIT: begin
                w_overrun   = reward_done;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tx_set     <= 1'b0;
            r_retry      <= '0;
            r_to_cnt     <= '0;
            r_tx_drop    <= 1'b0;
            r_tx_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_tx_set <= tx_setting;
            end
            if (w_clr_retry) begin
                r_retry <= '0;
            end else if (w_inc_retry) begin
                r_retry <= r_retry + RW'(1);
            end
            r_to_cnt     <= (r_state == S_WAIT_ACK) ? r_to_cnt + TW'(1) : '0;
            r_tx_drop    <= w_drop;
            r_tx_overrun <= w_overrun;
        end
    end

    // Energy ledger: RX and TX costs add, the result floors at zero, a load wins.
    assign w_tx_cost    = (r_state == S_DEBIT) ? (r_tx_set ? 16'h001B : 16'h0005) : 16'h0000;
    assign w_rx_cost    = rx_pkt ? 16'h0004 : 16'h0000;
    assign w_cost       = w_tx_cost + w_rx_cost;
    assign w_energy_nxt = energy_load ? energy_init
                        : ((r_energy >= w_cost) ? r_energy - w_cost : 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_energy <= 16'h0000;
            r_low_e  <= 1'b1;
        end else begin
            r_energy <= w_energy_nxt;
            r_low_e  <= (r_energy < LOW_E_THRESH);
        end
    end

    assign okToSend    = (r_state == S_GRANT);
    assign tx_pending  = (r_state != S_IDLE);
    assign slot_count  = r_slot;
    assign myEnergy    = r_energy;
    assign low_E       = r_low_e;
    assign tx_drop     = r_tx_drop;
    assign tx_overrun  = r_tx_overrun;
    assign o_dbg_state = r_state;

endmodule
